mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_if.sv | 25 ++
 rtl/mem_responder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// Load/store request and response channels between a core and mem_responder.
// The master modport is the core side; the slave modport is the responder side.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Single-port 64-bit word memory with a fixed-latency load/store responder.
// It accepts one request at a time and holds the response until the core takes it.
module mem_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic           clock,
    input  logic           reset,
    mem_responder_if.slave bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned TOP   = IDX_W + 3;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             commit_c, accept_c, rsp_hs_c;

    logic             lat_we, lat_uns;
    logic [1:0]       lat_size;
    logic [63:0]      lat_addr, lat_wdata;

    logic             cur_we, cur_uns;
    logic [1:0]       cur_size;
    logic [63:0]      cur_addr, cur_wdata;

    logic             req_ready_q, rsp_valid_q, rsp_err_q;
    logic [63:0]      rsp_rdata_q;

    logic [63:0]      mem [DEPTH];

    logic [IDX_W-1:0] idx_c;
    logic [2:0]       off_c;
    logic             err_c, align_err_c;
    logic [63:0]      word_c, shifted_c, load_c, wshift_c, merged_c;
    logic [3:0]       nbytes_c;

    assign accept_c = (state == S_IDLE) && req_ready_q && bus.req_valid && reset;
    assign rsp_hs_c = (state == S_RESP) && bus.rsp_ready;

    // With LATENCY=1 the commit happens on the accepting edge, so use the live bus fields.
    always_comb begin
        cur_we    = lat_we;
        cur_uns   = lat_uns;
        cur_size  = lat_size;
        cur_addr  = lat_addr;
        cur_wdata = lat_wdata;
        if (state == S_IDLE) begin
            cur_we    = bus.req_we;
            cur_uns   = bus.req_unsigned;
            cur_size  = bus.req_size;
            cur_addr  = bus.req_addr;
            cur_wdata = bus.req_wdata;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        commit_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept_c) begin
                    if (LATENCY == 1) begin
                        state_n  = S_RESP;
                        commit_c = 1'b1;
                    end else begin
                        state_n = S_WAIT;
                        cnt_n   = CNT_W'(LATENCY - 2);
                    end
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_n  = S_RESP;
                    commit_c = reset;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lat_we    <= 1'b0;
            lat_uns   <= 1'b0;
            lat_size  <= 2'd0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (accept_c) begin
            lat_we    <= bus.req_we;
            lat_uns   <= bus.req_unsigned;
            lat_size  <= bus.req_size;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
        end
    end

    // Address decode, error detection, byte-lane extraction and merge.
    always_comb begin
        idx_c    = cur_addr[TOP-1:3];
        off_c    = cur_addr[2:0];
        nbytes_c = 4'(4'd1 << cur_size);
        case (cur_size)
            2'd0:    align_err_c = 1'b0;
            2'd1:    align_err_c = cur_addr[0];
            2'd2:    align_err_c = |cur_addr[1:0];
            default: align_err_c = |cur_addr[2:0];
        endcase
        err_c     = (|cur_addr[63:TOP]) || align_err_c;
        word_c    = mem[idx_c];
        shifted_c = word_c >> {off_c, 3'b000};
        case (cur_size)
            2'd0:    load_c = cur_uns ? {56'd0, shifted_c[7:0]}  : {{56{shifted_c[7]}},  shifted_c[7:0]};
            2'd1:    load_c = cur_uns ? {48'd0, shifted_c[15:0]} : {{48{shifted_c[15]}}, shifted_c[15:0]};
            2'd2:    load_c = cur_uns ? {32'd0, shifted_c[31:0]} : {{32{shifted_c[31]}}, shifted_c[31:0]};
            default: load_c = shifted_c;
        endcase
        wshift_c = cur_wdata << {off_c, 3'b000};
        merged_c = word_c;
        for (int b = 0; b < 8; b++) begin
            if (({1'b0, off_c} <= 4'(b)) && (4'(b) < ({1'b0, off_c} + nbytes_c)))
                merged_c[b*8 +: 8] = wshift_c[b*8 +: 8];
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clock) begin
        if (commit_c && cur_we && !err_c) mem[idx_c] <= merged_c;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            req_ready_q <= (state_n == S_IDLE);
            if (commit_c) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= err_c;
                rsp_rdata_q <= (err_c || cur_we) ? 64'd0 : load_c;
            end else if (rsp_hs_c) begin
                rsp_valid_q <= 1'b0;
                rsp_err_q   <= 1'b0;
                rsp_rdata_q <= '0;
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule
